// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared types for the round-robin stream multiplexer
package stream_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin winner search starting just after ptr
module rr_pick #(
  parameter int N_CH = 4,
  localparam int SW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [SW-1:0]   idx,
  output logic            any
);
  logic [N_CH-1:0] rot;
  int off;
  // rotate so ptr+1 sits at bit 0, take the lowest request, rotate the index back
  always_comb begin
    rot = '0;
    for (int j = 0; j < N_CH; j++) rot[j] = req[(int'(ptr) + 1 + j) % N_CH];
    off = 0;
    any = 1'b0;
    for (int j = N_CH - 1; j >= 0; j--) if (rot[j]) begin off = j; any = 1'b1; end
    idx = SW'((int'(ptr) + 1 + off) % N_CH);
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-locked N-channel valid/ready mux with fixed or round-robin select
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 4,
  localparam int SW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [N_CH-1:0]      up_valid,
  input  logic [N_CH-1:0][W-1:0] up_data,
  input  logic [N_CH-1:0]      up_last,
  output logic [N_CH-1:0]      up_ready,
  output logic                 down_valid,
  output logic [W-1:0]         down_data,
  output logic                 down_last,
  input  logic                 down_ready,
  output logic [SW-1:0]        grant_id
);
  state_t state, state_nxt;
  logic [SW-1:0] lock_id, rr_ptr, cand, rr_idx;
  logic rr_any, elig, sel_ok, load_en, take;

  rr_pick #(.N_CH(N_CH)) u_pick (.req(up_valid), .ptr(rr_ptr), .idx(rr_idx), .any(rr_any));

  assign sel_ok  = int'(sel) < N_CH;
  assign load_en = !down_valid || down_ready;
  assign take    = load_en && elig;
  assign up_ready = take ? N_CH'(1) << cand : '0;

  // candidate: locked channel mid-packet, otherwise the fixed or round-robin winner
  always_comb begin
    cand = lock_id;
    elig = up_valid[lock_id];
    if (state == IDLE) begin
      cand = mode ? rr_idx : sel;
      elig = mode ? rr_any : sel_ok && up_valid[sel];
    end
  end

  // a non-last beat opens a packet, a last beat closes it
  always_comb begin
    state_nxt = take ? (up_last[cand] ? IDLE : LOCKED) : state;
  end

  // state, lock owner and round-robin pointer (advanced only at packet end)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= SW'(N_CH - 1);
    end else begin
      state <= state_nxt;
      if (take && !up_last[cand]) lock_id <= cand;
      if (take && up_last[cand]) rr_ptr <= cand;
    end
  end

  // output register: load on upstream transfer, drain to invalid when consumed, hold when stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      down_valid <= 1'b0;
      down_data  <= '0;
      down_last  <= 1'b0;
      grant_id   <= '0;
    end else if (take) begin
      down_valid <= 1'b1;
      down_data  <= up_data[cand];
      down_last  <= up_last[cand];
      grant_id   <= cand;
    end else if (load_en) begin
      down_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks on a 4x4 instance plus a randomized 3x8 soak
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b1;
  logic [1:0] sel = '0;
  logic [3:0] up_valid = '0;
  logic [3:0][3:0] up_data = '0;
  logic [3:0] up_last = '0;
  logic [3:0] up_ready;
  logic down_valid, down_last;
  logic [3:0] down_data;
  logic down_ready = 1'b1;
  logic [1:0] grant_id;

  logic rst3 = 1'b1;
  logic mode3 = 1'b1;
  logic [1:0] sel3 = '0;
  logic [2:0] uv3 = '0, ul3 = '0, ur3, acc = '0;
  logic [2:0][7:0] ud3 = '0;
  logic dv3, dl3, dr3 = 1'b1;
  logic [7:0] dd3;
  logic [1:0] gid3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .up_valid(up_valid), .up_data(up_data),
    .up_last(up_last), .up_ready(up_ready), .down_valid(down_valid), .down_data(down_data),
    .down_last(down_last), .down_ready(down_ready), .grant_id(grant_id));

  stream_mux_rr #(.N_CH(3), .W(8)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3), .up_valid(uv3), .up_data(ud3),
    .up_last(ul3), .up_ready(ur3), .down_valid(dv3), .down_data(dd3),
    .down_last(dl3), .down_ready(dr3), .grant_id(gid3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic l, input logic [1:0] g);
    chk({tag, "_valid"}, down_valid, v);
    chk({tag, "_data"}, down_data, d);
    chk({tag, "_last"}, down_last, l);
    chk({tag, "_gid"}, grant_id, g);
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [8:0] q[3][$];
  logic [5:0] seq[3];
  int wt[3];
  logic [8:0] exp_beat;

  initial begin
    for (int c = 0; c < 3; c++) begin seq[c] = '0; wt[c] = 0; end
    repeat (2) @(negedge clk);
    chk_out("reset", 1'b0, 4'h0, 1'b0, 2'd0);
    rst = 1'b0;
    up_valid = 4'b0101; up_data[0] = 4'h1; up_data[2] = 4'h2; up_last = 4'b1111;
    #1 chk("rr_first_ready", up_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      cyc;
      chk_out("rr_alt", 1'b1, (k % 2) ? 4'h2 : 4'h1, 1'b1, (k % 2) ? 2'd2 : 2'd0);
      chk("rr_alt_ready", up_ready, (k % 2) ? 4'b0001 : 4'b0100);
    end
    up_valid = 4'b0010; up_data[1] = 4'hA; up_last = 4'b1000; up_data[3] = 4'h5;
    #1 chk("lock_ready0", up_ready, 4'b0010);
    cyc;
    chk_out("lock_a", 1'b1, 4'hA, 1'b0, 2'd1);
    up_valid = 4'b1010; up_data[1] = 4'hB;
    #1 chk("lock_ready1", up_ready, 4'b0010);
    cyc;
    chk_out("lock_b", 1'b1, 4'hB, 1'b0, 2'd1);
    up_data[1] = 4'hC; up_last[1] = 1'b1;
    #1 chk("lock_ready2", up_ready, 4'b0010);
    cyc;
    chk_out("lock_c", 1'b1, 4'hC, 1'b1, 2'd1);
    up_valid = 4'b1000;
    #1 chk("after_lock_ready", up_ready, 4'b1000);
    cyc;
    chk_out("after_lock", 1'b1, 4'h5, 1'b1, 2'd3);
    mode = 1'b0; sel = 2'd2; up_valid = 4'b1111;
    up_data[0] = 4'h4; up_data[1] = 4'h6; up_data[2] = 4'hD; up_last = 4'b1011;
    #1 chk("fix_ready0", up_ready, 4'b0100);
    cyc;
    chk_out("fix_d", 1'b1, 4'hD, 1'b0, 2'd2);
    sel = 2'd1; up_data[2] = 4'hE; up_last[2] = 1'b1;
    #1 chk("fix_ready_locked", up_ready, 4'b0100);
    cyc;
    chk_out("fix_e", 1'b1, 4'hE, 1'b1, 2'd2);
    chk("fix_ready_sel1", up_ready, 4'b0010);
    cyc;
    chk_out("fix_ch1", 1'b1, 4'h6, 1'b1, 2'd1);
    down_ready = 1'b0; up_data[1] = 4'h7;
    #1 chk("bp_ready0", up_ready, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      cyc;
      chk_out("bp_hold", 1'b1, 4'h6, 1'b1, 2'd1);
      chk("bp_ready", up_ready, 4'b0000);
    end
    down_ready = 1'b1;
    #1 chk("bp_release_ready", up_ready, 4'b0010);
    cyc;
    chk_out("bp_next", 1'b1, 4'h7, 1'b1, 2'd1);
    up_valid = 4'b0000;
    cyc;
    chk_out("drain", 1'b0, 4'h7, 1'b1, 2'd1);
    mode = 1'b1; up_valid = 4'b0100; up_data[2] = 4'h9; up_last[2] = 1'b0;
    #1 chk("mid_ready", up_ready, 4'b0100);
    cyc;
    chk_out("mid_beat", 1'b1, 4'h9, 1'b0, 2'd2);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 4'h0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    up_valid = 4'b0101; up_data[0] = 4'h1; up_data[2] = 4'h2; up_last = 4'b1111;
    #1 chk("post_rst_ready", up_ready, 4'b0001);
    cyc;
    chk_out("post_rst", 1'b1, 4'h1, 1'b1, 2'd0);
    up_valid = '0;

    @(negedge clk);
    rst3 = 1'b0;
    for (int i = 0; i < 2020; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (acc[c]) seq[c]++;
        if (!uv3[c] || acc[c]) begin
          uv3[c] = (i < 2000) && ($urandom_range(0, 9) < 7);
          ud3[c] = {2'(c), seq[c]};
          ul3[c] = ($urandom_range(0, 2) == 0);
        end
      end
      dr3 = (i >= 2000) || ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) mode3 = ~mode3;
      sel3 = 2'($urandom_range(0, 2));
      #1;
      acc = uv3 & ur3;
      if (dv3 && dr3) begin
        if (gid3 > 2'd2) chk("soak_gid_range", gid3, 2'd0);
        else if (q[gid3].size() == 0) chk("soak_unexpected", 1, 0);
        else begin
          exp_beat = q[gid3].pop_front();
          chk("soak_beat", {dl3, dd3}, exp_beat);
        end
      end
      for (int c = 0; c < 3; c++) if (acc[c]) q[c].push_back({ul3[c], ud3[c]});
      for (int c = 0; c < 3; c++) begin
        if (!mode3 || !uv3[c] || acc[c]) wt[c] = 0;
        else for (int o = 0; o < 3; o++)
          if (o != c && acc[o] && ul3[o]) begin
            wt[c]++;
            chk("rr_fair", wt[c] <= 2, 1);
          end
      end
    end
    for (int c = 0; c < 3; c++) chk("soak_drain", q[c].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit valid/ready stream multiplexer with a registered output. It selects one upstream channel either from an external select (fixed mode) or by round-robin arbitration, and holds that selection for a whole packet. Channels are delimited by `last`. It is the sequential, back-pressure-aware generalisation of the team's combinational 2:1/4:1 muxes and sits between multiple producers and a single shared consumer.

## Interface
Parameters:
- `N_CH`, 4: number of upstream channels, ≥2.
- `W`, 4: data width, ≥1.
- `SW`, `$clog2(N_CH)`: select/grant width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `mode`  in  1  0 = fixed select via `sel`, 1 = round-robin.
- `sel`  in  SW  channel index used in fixed mode.
- `up_valid`  in  N_CH  per-channel beat valid.
- `up_data`  in  N_CH×W  per-channel data, packed `[N_CH-1:0][W-1:0]`.
- `up_last`  in  N_CH  per-channel end-of-packet flag.
- `up_ready`  out  N_CH  per-channel accept; at most one bit high.
- `down_valid`  out  1  output beat valid (registered).
- `down_data`  out  W  output data (registered).
- `down_last`  out  1  output end-of-packet (registered).
- `down_ready`  in  1  consumer accept.
- `grant_id`  out  SW  channel index of the beat currently on `down_*` (registered).

## Operation
- Transfer rule: an upstream beat on channel i moves when `up_valid[i] && up_ready[i]`; a downstream beat moves when `down_valid && down_ready`.
- `load_en = !down_valid || down_ready`. `up_ready[i] = load_en && (i == cand)`, where `cand` is defined below. Data is never dropped or duplicated.
- FSM states:
  - IDLE: no packet open. `cand` is the arbitration winner.
    - Fixed mode: `cand = sel`, eligible only if `up_valid[sel]`.
    - RR mode: `cand` is the first valid channel searching `rr_ptr+1, rr_ptr+2, …` modulo N_CH.
    - If no candidate is eligible, all `up_ready` are 0.
    - An accepted beat with `last=0` → LOCKED, with `lock_id = cand`.
    - An accepted beat with `last=1` → stay IDLE and set `rr_ptr = cand`.
  - LOCKED: `cand = lock_id` regardless of `mode`, `sel` or other valids.
    - An accepted beat with `last=1` → IDLE and set `rr_ptr = lock_id`.
- `rr_ptr` updates only on packet completion, in both modes, so RR fairness resumes correctly after a fixed-mode stretch.
- `mode` and `sel` are sampled only in IDLE. Changes while LOCKED take effect at the next packet boundary.
- The output register loads `{data, last, grant_id}` from `cand` on an upstream transfer.
  - If `load_en` holds and there is no upstream transfer, `down_valid` drops to 0. Data and ID hold their old values.
  - If `down_valid && !down_ready`, all `down_*` and `grant_id` hold stable.
- Out-of-range `sel` (≥ N_CH when N_CH is not a power of 2): treated as no candidate; no `up_ready` asserted.

## Timing
- Reset values: `down_valid=0`, `down_data=0`, `down_last=0`, `grant_id=0`, state IDLE, `lock_id=0`, `rr_ptr=N_CH-1` (so channel 0 wins first).
- `up_ready` is combinational from state, valids, `mode`, `sel` and `down_ready`. There is no combinational path from `up_data` to `down_*`.
- Latency: upstream acceptance at edge k gives `down_valid` high in the cycle after edge k (1 cycle).
- Throughput: 1 beat/cycle while `down_ready=1`, including back-to-back packets from different channels with no bubble.
- Simultaneous events: a downstream transfer and a new upstream load in the same cycle replace the register contents with no gap.
- Reset mid-packet: immediate return to the reset values above. The partially transferred packet is abandoned and the consumer sees no `last`.

## Structure
- Package `stream_mux_pkg`: `typedef enum logic {IDLE, LOCKED} state_t`.
- Sub-module `rr_pick`, parametrised by N_CH:
  - inputs: request vector, `rr_ptr`
  - outputs: winner index and `any` flag
  - purely combinational, using a rotate, a priority search and a rotate-back.
- Top module: FSM, lock/pointer registers, candidate mux, output register.

## Test plan
- Reset, then ch0 and ch2 both valid with single-beat packets (D=0x1, 0x2, `last=1`), `down_ready=1`, RR mode → output order 0x1 (`grant_id`=0), 0x2 (`grant_id`=2), alternating. Second beat appears on the cycle after the first.
- RR mode, ch1 sends a 3-beat packet (0xA, 0xB, 0xC with `last` on 0xC) while ch3 stays valid → three ch1 beats contiguous, then ch3. `up_ready[3]` is 0 throughout the lock.
- Fixed mode, `sel=2`, ch0–ch3 all valid → only ch2 is served. `sel` changes to 1 mid-packet → ch2 finishes its packet, then ch1 is served.
- Back-pressure: `down_ready=0` for 3 cycles while `down_valid=1` → `down_data`, `down_last` and `grant_id` are stable and every `up_ready` is 0. On `down_ready=1` the flow continues with no loss or duplication; the scoreboard matches per-channel order.
- `rst` asserted mid-packet, between edges → outputs go to 0 immediately without waiting for an edge. After release, ch0 wins first with RR.
- Random soak, N_CH=3, W=8, random valids/last/`down_ready`/`mode` → per-channel packets arrive intact and in order, with no interleaving inside a packet. In RR mode, a channel held valid waits no more than N_CH-1 other packets.
